imm_extend_unit: RTL

// - Parametrised immediate-extension stage for the 16-bit datapath; next generation of the fixed 8->16 zero extender.
// - Extends an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper-place, sign+shift-left-1.
// - Registered output behind a 2-entry skid buffer with valid/ready on both sides.
// - Sits between instruction decode (producer) and ALU operand mux / branch adder (consumer).

---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_ext_core.sv | 31 +++
 rtl/imm_extend_unit.sv | 76 +++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared encodings for the immediate-extension stage
package imm_ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_ZERO  = 2'd0;
    localparam ext_mode_t EXT_SIGN  = 2'd1;
    localparam ext_mode_t EXT_UPPER = 2'd2;
    localparam ext_mode_t EXT_SHL1  = 2'd3;

    // Occupancy of the head/skid output buffer
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational IN_W -> OUT_W immediate extender
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_imm,
    input  logic [1:0]       i_mode,
    output logic [OUT_W-1:0] o_result
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sign;

    assign w_sign = {{PAD_W{i_imm[IN_W-1]}}, i_imm};

    always_comb begin
        o_result = '0;
        case (i_mode)
            EXT_ZERO:  o_result = {{PAD_W{1'b0}}, i_imm};
            EXT_SIGN:  o_result = w_sign;
            EXT_UPPER: o_result = {i_imm, {PAD_W{1'b0}}};
            // Branch word offset: sign-extended value doubled, top bit falls off
            EXT_SHL1:  o_result = {w_sign[OUT_W-2:0], 1'b0};
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate extender with registered 2-entry skid output
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    logic [1:0]       r_count;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_skid;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm    (in_imm),
        .i_mode   (in_mode),
        .o_result (w_ext)
    );

    // in_ready is a pure function of state so decode never sees a comb path from out_ready
    assign in_ready  = ~reset & (r_count != CNT_FULL);
    assign out_valid = (r_count != CNT_EMPTY);
    assign out_data  = r_head;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= CNT_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_count)
                CNT_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_ext;
                        r_count <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_ext;
                    end else if (w_push) begin
                        r_skid  <= w_ext;
                        r_count <= CNT_FULL;
                    end else if (w_pop) begin
                        r_count <= CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_count <= CNT_ONE;
                    end
                end
                default: r_count <= CNT_EMPTY;
            endcase
        end
    end

endmodule
